// File: rtl/time_set_ctrl.sv
// Time-setting controller for the 24-hour clock: freezes the counter, edits hr/min/sec
// with mode/inc/dec (with auto-repeat), then loads the edited value back.
module time_set_ctrl #(
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100,
    parameter int unsigned TIMEOUT      = 10000,
    parameter int unsigned BLINK_HALF   = 250
) (
    input  logic        kh_clk,
    input  logic        reset,
    input  logic        mode_btn,
    input  logic        inc_btn,
    input  logic        dec_btn,
    input  logic        cancel_btn,
    input  logic [26:0] cur_time,
    output logic        run_en,
    output logic        load,
    output logic [26:0] load_time,
    output logic [16:0] edit_time,
    output logic [1:0]  field_sel,
    output logic        blink
);

    localparam int unsigned HoldW  = $clog2(REPEAT_DELAY + 1);
    localparam int unsigned IdleW  = $clog2(TIMEOUT + 1);
    localparam int unsigned BlinkW = $clog2(BLINK_HALF + 1);

    localparam logic [HoldW-1:0]  HoldMax   = HoldW'(REPEAT_DELAY);
    // Re-arming here makes the next step land exactly REPEAT_RATE edges later.
    localparam logic [HoldW-1:0]  HoldRearm = HoldW'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [IdleW-1:0]  IdleMax   = IdleW'(TIMEOUT);
    localparam logic [BlinkW-1:0] BlinkMax  = BlinkW'(BLINK_HALF);

    // Encoding doubles as the field_sel value.
    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetHr  = 2'd1,
        StSetMin = 2'd2,
        StSetSec = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              mode_q, inc_q, dec_q, cancel_q;
    logic [4:0]        hr_q, hr_d;
    logic [5:0]        min_q, min_d;
    logic [5:0]        sec_q, sec_d;
    logic              run_en_q, run_en_d;
    logic              load_q, load_d;
    logic [26:0]       load_time_q, load_time_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d;

    logic mode_press, inc_press, dec_press, cancel_press, any_press;
    logic step, step_up;
    logic unused_ms;

    assign unused_ms = ^cur_time[9:0];

    assign mode_press   = mode_btn & ~mode_q;
    assign inc_press    = inc_btn & ~inc_q;
    assign dec_press    = dec_btn & ~dec_q;
    assign cancel_press = cancel_btn & ~cancel_q;
    assign any_press    = mode_press | inc_press | dec_press | cancel_press;
    assign step_up      = inc_btn;

    always_comb begin
        state_d     = state_q;
        hr_d        = hr_q;
        min_d       = min_q;
        sec_d       = sec_q;
        run_en_d    = run_en_q;
        load_d      = 1'b0;
        load_time_d = load_time_q;
        hold_d      = '0;
        idle_d      = '0;
        blink_d     = 1'b1;
        blink_cnt_d = '0;
        step        = 1'b0;

        if (state_q == StRun) begin
            if (mode_press) begin
                {hr_d, min_d, sec_d} = cur_time[26:10];
                run_en_d             = 1'b0;
                state_d              = StSetHr;
            end
        end else begin
            idle_d = idle_q + 1'b1;
            if (cancel_press) begin
                state_d  = StRun;
                run_en_d = 1'b1;
            end else if (mode_press) begin
                case (state_q)
                    StSetHr:  state_d = StSetMin;
                    StSetMin: state_d = StSetSec;
                    default: begin
                        load_d      = 1'b1;
                        load_time_d = {hr_q, min_q, sec_q, 10'd0};
                        run_en_d    = 1'b1;
                        state_d     = StRun;
                    end
                endcase
            end else begin
                if ((inc_press & ~dec_btn) | (dec_press & ~inc_btn)) begin
                    step = 1'b1;
                end else if (inc_btn ^ dec_btn) begin
                    if (hold_q + 1'b1 == HoldMax) begin
                        step   = 1'b1;
                        hold_d = HoldRearm;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                if (!step && !any_press && (idle_q + 1'b1 == IdleMax)) begin
                    state_d  = StRun;
                    run_en_d = 1'b1;
                end
            end
        end

        if (step) begin
            case (state_q)
                StSetHr: begin
                    if (step_up) hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
                    else         hr_d = (hr_q == 5'd0) ? 5'd23 : hr_q - 5'd1;
                end
                StSetMin: begin
                    if (step_up) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                    else         min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
                end
                StSetSec: begin
                    if (step_up) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                    else         sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
                end
                default: ;
            endcase
        end

        if (state_d != state_q) hold_d = '0;
        if (state_d == StRun || any_press || step) idle_d = '0;

        if (state_d != StRun) begin
            if (state_d != state_q || step) begin
                blink_d     = 1'b1;
                blink_cnt_d = '0;
            end else if (blink_cnt_q + 1'b1 == BlinkMax) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge kh_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            mode_q      <= 1'b1;
            inc_q       <= 1'b1;
            dec_q       <= 1'b1;
            cancel_q    <= 1'b1;
            hr_q        <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            run_en_q    <= 1'b1;
            load_q      <= 1'b0;
            load_time_q <= '0;
            hold_q      <= '0;
            idle_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_btn;
            inc_q       <= inc_btn;
            dec_q       <= dec_btn;
            cancel_q    <= cancel_btn;
            hr_q        <= hr_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            run_en_q    <= run_en_d;
            load_q      <= load_d;
            load_time_q <= load_time_d;
            hold_q      <= hold_d;
            idle_q      <= idle_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign run_en    = run_en_q;
    assign load      = load_q;
    assign load_time = load_time_q;
    assign edit_time = {hr_q, min_q, sec_q};
    assign field_sel = state_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl; load_time values are scoreboarded through a queue.
module tb_time_set_ctrl;

    logic        kh_clk;
    logic        reset;
    logic        mode_btn, inc_btn, dec_btn, cancel_btn;
    logic [26:0] cur_time;
    logic        run_en, load, blink;
    logic [26:0] load_time;
    logic [16:0] edit_time;
    logic [1:0]  field_sel;

    int checks = 0;
    int errors = 0;
    int load_count = 0;
    logic [26:0] exp_q[$];

    time_set_ctrl dut (
        .kh_clk     (kh_clk),
        .reset      (reset),
        .mode_btn   (mode_btn),
        .inc_btn    (inc_btn),
        .dec_btn    (dec_btn),
        .cancel_btn (cancel_btn),
        .cur_time   (cur_time),
        .run_en     (run_en),
        .load       (load),
        .load_time  (load_time),
        .edit_time  (edit_time),
        .field_sel  (field_sel),
        .blink      (blink)
    );

    initial kh_clk = 1'b0;
    always #5 kh_clk = ~kh_clk;

    function automatic logic [16:0] hms(input int h, input int m, input int s);
        return {5'(h), 6'(m), 6'(s)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge kh_clk);
        #1;
    endtask

    task automatic pulse_mode();
        mode_btn = 1'b1; tick(); mode_btn = 1'b0; tick();
    endtask

    task automatic pulse_inc();
        inc_btn = 1'b1; tick(); inc_btn = 1'b0; tick();
    endtask

    task automatic pulse_dec();
        dec_btn = 1'b1; tick(); dec_btn = 1'b0; tick();
    endtask

    task automatic pulse_cancel();
        cancel_btn = 1'b1; tick(); cancel_btn = 1'b0; tick();
    endtask

    // Scoreboard consumer: every load pulse must match the oldest expected value.
    always @(negedge kh_clk) begin
        if (load === 1'b1) begin
            load_count++;
            check("load_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("load_time", 32'(load_time), 32'(exp_q.pop_front()));
            check("run_en_at_load", 32'(run_en), 32'd1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        mode_btn   = 1'b1;
        inc_btn    = 1'b0;
        dec_btn    = 1'b0;
        cancel_btn = 1'b0;
        cur_time   = '0;
        repeat (3) tick();

        // Reset values, and mode held through reset release gives no press
        check("rst_run_en", 32'(run_en), 32'd1);
        check("rst_load", 32'(load), 32'd0);
        check("rst_load_time", 32'(load_time), 32'd0);
        check("rst_edit_time", 32'(edit_time), 32'd0);
        check("rst_field_sel", 32'(field_sel), 32'd0);
        check("rst_blink", 32'(blink), 32'd1);
        reset = 1'b1;
        repeat (3) tick();
        check("held_mode_field", 32'(field_sel), 32'd0);
        check("held_mode_run_en", 32'(run_en), 32'd1);
        mode_btn = 1'b0;
        tick();
        check("held_mode_no_load", 32'(load_count), 32'd0);

        // Full edit sequence from 13:45:30.250
        cur_time = {hms(13, 45, 30), 10'd250};
        pulse_mode();
        check("cap_field", 32'(field_sel), 32'd1);
        check("cap_run_en", 32'(run_en), 32'd0);
        check("cap_edit", 32'(edit_time), 32'(hms(13, 45, 30)));
        pulse_inc();
        pulse_inc();
        check("hr_inc2", 32'(edit_time), 32'(hms(15, 45, 30)));
        pulse_mode();
        check("to_min", 32'(field_sel), 32'd2);
        pulse_dec();
        pulse_mode();
        check("to_sec", 32'(field_sel), 32'd3);
        pulse_inc();
        check("edit_final", 32'(edit_time), 32'(hms(15, 44, 31)));
        exp_q.push_back({hms(15, 44, 31), 10'd0});
        pulse_mode();
        check("load_once", 32'(load_count), 32'd1);
        check("load_low_after", 32'(load), 32'd0);
        check("back_run_field", 32'(field_sel), 32'd0);
        check("back_run_en", 32'(run_en), 32'd1);

        // Wraps
        cur_time = {hms(23, 0, 0), 10'd0};
        pulse_mode();
        pulse_inc();
        check("hr_wrap_up", 32'(edit_time), 32'(hms(0, 0, 0)));
        pulse_dec();
        check("hr_wrap_down", 32'(edit_time), 32'(hms(23, 0, 0)));
        pulse_mode();
        pulse_mode();
        pulse_dec();
        check("sec_wrap_down", 32'(edit_time), 32'(hms(23, 0, 59)));
        pulse_cancel();
        check("cancel_field", 32'(field_sel), 32'd0);
        check("cancel_run_en", 32'(run_en), 32'd1);
        check("cancel_no_load", 32'(load_count), 32'd1);
        check("cancel_edit_kept", 32'(edit_time), 32'(hms(23, 0, 59)));

        // Auto-repeat: hold inc for 1000 cycles in SET_MIN
        cur_time = {hms(1, 0, 0), 10'd0};
        pulse_mode();
        pulse_mode();
        inc_btn = 1'b1;
        tick();
        check("rep_press", 32'(edit_time), 32'(hms(1, 1, 0)));
        repeat (499) tick();
        check("rep_before_500", 32'(edit_time), 32'(hms(1, 1, 0)));
        tick();
        check("rep_at_500", 32'(edit_time), 32'(hms(1, 2, 0)));
        repeat (99) tick();
        check("rep_before_600", 32'(edit_time), 32'(hms(1, 2, 0)));
        tick();
        check("rep_at_600", 32'(edit_time), 32'(hms(1, 3, 0)));
        check("rep_blink_restart", 32'(blink), 32'd1);
        repeat (399) tick();
        inc_btn = 1'b0;
        tick();
        check("rep_final", 32'(edit_time), 32'(hms(1, 6, 0)));

        // mode and inc on the same edge: advance only
        mode_btn = 1'b1;
        inc_btn  = 1'b1;
        tick();
        check("mode_inc_field", 32'(field_sel), 32'd3);
        check("mode_inc_edit", 32'(edit_time), 32'(hms(1, 6, 0)));
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        tick();

        // inc and dec together: no step, even when held past the repeat delay
        inc_btn = 1'b1;
        dec_btn = 1'b1;
        tick();
        check("incdec_press", 32'(edit_time), 32'(hms(1, 6, 0)));
        repeat (600) tick();
        check("incdec_hold", 32'(edit_time), 32'(hms(1, 6, 0)));
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        tick();
        pulse_cancel();
        check("cancel2_field", 32'(field_sel), 32'd0);

        // Blink and timeout in SET_SEC
        cur_time = {hms(2, 3, 4), 10'd0};
        pulse_mode();
        pulse_mode();
        mode_btn = 1'b1;
        tick();
        mode_btn = 1'b0;
        check("to_enter_field", 32'(field_sel), 32'd3);
        check("to_enter_blink", 32'(blink), 32'd1);
        repeat (249) tick();
        check("blink_before_half", 32'(blink), 32'd1);
        tick();
        check("blink_at_half", 32'(blink), 32'd0);
        repeat (9749) tick();
        check("timeout_not_yet", 32'(field_sel), 32'd3);
        tick();
        check("timeout_field", 32'(field_sel), 32'd0);
        check("timeout_run_en", 32'(run_en), 32'd1);
        check("timeout_no_load", 32'(load_count), 32'd1);

        // Asynchronous reset mid-edit
        pulse_mode();
        pulse_inc();
        check("pre_reset_edit", 32'(edit_time), 32'(hms(3, 3, 4)));
        #2 reset = 1'b0;
        #1;
        check("async_rst_field", 32'(field_sel), 32'd0);
        check("async_rst_run_en", 32'(run_en), 32'd1);
        check("async_rst_edit", 32'(edit_time), 32'd0);
        check("async_rst_blink", 32'(blink), 32'd1);
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("final_load_count", 32'(load_count), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Time-setting controller for the 24-hour digital clock. Sequences the clock counter between running and editing: freezes it, lets the user edit hours, minutes and seconds with mode/inc/dec buttons (including auto-repeat), then loads the edited value back in a single-cycle load strobe. Sits between the debounced front-panel buttons and the 24-hour time counter, and drives the display's field-blink control.

## Interface
- REPEAT_DELAY, 500, hold cycles before inc/dec auto-repeat starts (500 ms at 1 kHz)
- REPEAT_RATE, 100, cycles between auto-repeat steps once repeating
- TIMEOUT, 10000, idle cycles in any SET state before automatic cancel
- BLINK_HALF, 250, cycles per blink half-period
- kh_clk  input  1  1 kHz system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- mode_btn  input  1  debounced, synchronized level; press advances mode
- inc_btn  input  1  debounced level; increments selected field
- dec_btn  input  1  debounced level; decrements selected field
- cancel_btn  input  1  debounced level; abandons edit
- cur_time  input  27  live time {hr[4:0], min[5:0], sec[5:0], ms[9:0]} from the counter
- run_en  output  1  counter enable; 1 = clock advances
- load  output  1  one-cycle strobe: counter takes load_time
- load_time  output  27  value to load {hr, min, sec, 10'd0}
- edit_time  output  17  {hr, min, sec} being edited, for display
- field_sel  output  2  0 = none, 1 = hr, 2 = min, 3 = sec
- blink  output  1  1 = selected field visible, 0 = blanked

## Operation
- Press detect per button: press = btn & ~btn_q; btn_q registers reset to 1, so a button held through reset release produces no press.
- States: RUN, SET_HR, SET_MIN, SET_SEC. Reset -> RUN.
- RUN: run_en = 1, field_sel = 0, blink = 1. mode press -> capture cur_time hr/min/sec into edit register, run_en <= 0, -> SET_HR. inc/dec/cancel ignored.
- SET_HR -> SET_MIN -> SET_SEC on mode press. mode press in SET_SEC: load <= 1, load_time <= {edit, 10'd0}, run_en <= 1, -> RUN.
- cancel press in any SET state: -> RUN, run_en <= 1, no load; counter resumes from its frozen value.
- inc/dec edit only the selected field. Ranges: hr 0..23, min/sec 0..59. Wrap: 23+1 -> 0, 0-1 -> 23; 59+1 -> 0, 0-1 -> 59. Other fields untouched.
- Auto-repeat: holding inc (or dec) alone steps once on press, again after REPEAT_DELAY cycles of continuous hold, then every REPEAT_RATE cycles. Release or state change clears the hold counter.
- Priority on the same edge: cancel > mode > inc/dec. inc and dec both high: no step, hold counter cleared.
- Timeout: idle counter clears on any press or repeat step; reaching TIMEOUT in a SET state acts as cancel.
- Blink: counter toggles blink every BLINK_HALF cycles in SET states; restarts with blink = 1 on entry to each SET state and on every step. Forced 1 in RUN.
- edit_time tracks the edit register; in RUN it shows the last captured or edited value.

## Timing
- Reset values: run_en = 1, load = 0, load_time = 0, edit_time = 0, field_sel = 0, blink = 1, state RUN, all counters 0.
- All outputs registered. Press sampled at edge k takes effect at edge k (state, edit_time, field_sel valid after edge k).
- Capture on RUN -> SET_HR uses cur_time sampled at edge k; run_en low from edge k, so the counter performs no further increments.
- load high for exactly one cycle, after edge k; run_en rises at the same edge. The counter gives load priority over increment.
- First auto-repeat step occurs at edge p + REPEAT_DELAY (press at edge p); subsequent steps occur every REPEAT_RATE edges.
- Reset asserted mid-edit: immediate return to RUN, edit discarded, no load pulse.

## Test plan
- Reset with mode_btn held high, then release reset: no press, state RUN, run_en = 1, load never pulses.
- cur_time = 13:45:30.250, then mode, inc x2, mode, dec, mode, inc, mode: exactly one load pulse, load_time = 15:44:31.000, run_en = 1 on the same cycle.
- Wrap: hr = 23, inc -> 0, dec -> 23; sec = 0, dec -> 59.
- Hold inc 1000 cycles in SET_MIN from min = 0: steps at 0, 500, 600, 700, 800, 900; final min = 6.
- Boundaries: mode and inc on the same edge -> state advances, no step; inc and dec together -> no change.
- Cancel press, then separately TIMEOUT idle cycles in SET_SEC: both return to RUN with no load; reset asserted mid-edit also gives RUN with no load.
